// File: rtl/friscv_icache_line_loader.sv
// Instruction-cache line loader: turns one line-miss request into an AXI4 INCR read burst and
// assembles the returned beats into a full cache line, written back in a single cycle.
module friscv_icache_line_loader #(
    parameter int AXI_ADDR_W   = 32,
    parameter int AXI_ID_W     = 8,
    parameter int AXI_DATA_W   = 32,
    parameter int CACHE_LINE_W = 128
)(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    input  logic                    memctrl_arvalid,
    output logic                    memctrl_arready,
    input  logic [AXI_ADDR_W-1:0]   memctrl_araddr,
    input  logic [2:0]              memctrl_arprot,
    input  logic [AXI_ID_W-1:0]     memctrl_arid,
    output logic                    mem_arvalid,
    input  logic                    mem_arready,
    output logic [AXI_ADDR_W-1:0]   mem_araddr,
    output logic [7:0]              mem_arlen,
    output logic [2:0]              mem_arsize,
    output logic [1:0]              mem_arburst,
    output logic [2:0]              mem_arprot,
    output logic [AXI_ID_W-1:0]     mem_arid,
    input  logic                    mem_rvalid,
    output logic                    mem_rready,
    input  logic [AXI_ID_W-1:0]     mem_rid,
    input  logic [1:0]              mem_rresp,
    input  logic [AXI_DATA_W-1:0]   mem_rdata,
    input  logic                    mem_rlast,
    output logic                    cache_writing,
    output logic                    cache_wen,
    output logic [AXI_ADDR_W-1:0]   cache_waddr,
    output logic [CACHE_LINE_W-1:0] cache_wdata,
    output logic                    load_err
);

    localparam int BEATS    = CACHE_LINE_W / AXI_DATA_W;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(CACHE_LINE_W / 8);

    localparam logic [7:0] ARLEN  = 8'(BEATS - 1);
    localparam logic [2:0] ARSIZE = 3'($clog2(AXI_DATA_W / 8));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [AXI_ID_W-1:0]     id_q, id_d;
    logic [2:0]              prot_q, prot_d;
    logic [CACHE_LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic                    err_q, err_d;

    logic in_req;
    logic in_write;
    logic unused_bits;

    assign unused_bits = ^{mem_rid, memctrl_araddr[OFFSET_W-1:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        prot_d  = prot_q;
        line_d  = line_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (memctrl_arvalid && memctrl_arready) begin
                    addr_d  = {memctrl_araddr[AXI_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    id_d    = memctrl_arid;
                    prot_d  = memctrl_arprot;
                    line_d  = '0;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_arready) state_d = FILL;
            end
            FILL: begin
                if (mem_rvalid) begin
                    line_d[int'(beat_q) * AXI_DATA_W +: AXI_DATA_W] = mem_rdata;
                    beat_d = beat_q + 1'b1;
                    if (mem_rresp != 2'b00) err_d = 1'b1;
                    // A short burst (early rlast) leaves the untouched slices at zero
                    if (mem_rlast || beat_q == LAST_BEAT) state_d = WRITE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            prot_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else if (srst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            prot_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            prot_q  <= prot_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign in_req   = (state_q == REQ);
    assign in_write = (state_q == WRITE);

    // Held off while either reset is active so no request is lost to a reset edge
    assign memctrl_arready = (state_q == IDLE) && aresetn && !srst;

    assign mem_arvalid = in_req;
    assign mem_araddr  = in_req ? addr_q : '0;
    assign mem_arlen   = in_req ? ARLEN : '0;
    assign mem_arsize  = in_req ? ARSIZE : '0;
    assign mem_arburst = in_req ? 2'b01 : '0;
    assign mem_arprot  = in_req ? prot_q : '0;
    assign mem_arid    = in_req ? id_q : '0;
    assign mem_rready  = (state_q == FILL);

    assign cache_wen     = in_write;
    assign cache_writing = in_write;
    assign cache_waddr   = in_write ? addr_q : '0;
    assign cache_wdata   = in_write ? line_q : '0;
    assign load_err      = in_write && err_q;

endmodule

// File: tb/tb_friscv_icache_line_loader.sv
// Self-checking bench for friscv_icache_line_loader (32-bit data, 128-bit line, 4 beats);
// expectations come from a line-level model of the requested burst.
module tb_friscv_icache_line_loader;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         srst = 1'b0;
    logic         memctrl_arvalid = 1'b0;
    logic         memctrl_arready;
    logic [31:0]  memctrl_araddr = '0;
    logic [2:0]   memctrl_arprot = '0;
    logic [7:0]   memctrl_arid = '0;
    logic         mem_arvalid;
    logic         mem_arready = 1'b0;
    logic [31:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic [2:0]   mem_arsize;
    logic [1:0]   mem_arburst;
    logic [2:0]   mem_arprot;
    logic [7:0]   mem_arid;
    logic         mem_rvalid = 1'b0;
    logic         mem_rready;
    logic [7:0]   mem_rid = '0;
    logic [1:0]   mem_rresp = '0;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rlast = 1'b0;
    logic         cache_writing;
    logic         cache_wen;
    logic [31:0]  cache_waddr;
    logic [127:0] cache_wdata;
    logic         load_err;

    friscv_icache_line_loader #(
        .AXI_ADDR_W   (32),
        .AXI_ID_W     (8),
        .AXI_DATA_W   (32),
        .CACHE_LINE_W (128)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .srst            (srst),
        .memctrl_arvalid (memctrl_arvalid),
        .memctrl_arready (memctrl_arready),
        .memctrl_araddr  (memctrl_araddr),
        .memctrl_arprot  (memctrl_arprot),
        .memctrl_arid    (memctrl_arid),
        .mem_arvalid     (mem_arvalid),
        .mem_arready     (mem_arready),
        .mem_araddr      (mem_araddr),
        .mem_arlen       (mem_arlen),
        .mem_arsize      (mem_arsize),
        .mem_arburst     (mem_arburst),
        .mem_arprot      (mem_arprot),
        .mem_arid        (mem_arid),
        .mem_rvalid      (mem_rvalid),
        .mem_rready      (mem_rready),
        .mem_rid         (mem_rid),
        .mem_rresp       (mem_rresp),
        .mem_rdata       (mem_rdata),
        .mem_rlast       (mem_rlast),
        .cache_writing   (cache_writing),
        .cache_wen       (cache_wen),
        .cache_waddr     (cache_waddr),
        .cache_wdata     (cache_wdata),
        .load_err        (load_err)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-load stimulus
    logic [31:0] bdata [4];
    logic [1:0]  bresp [4];
    int          gaps  [4];

    // Per-load observations
    logic         obs_arready_idle, obs_arvalid, obs_writing, obs_err, obs_arready_after;
    logic [31:0]  obs_araddr, obs_waddr;
    logic [7:0]   obs_arlen, obs_arid;
    logic [2:0]   obs_arsize, obs_arprot;
    logic [1:0]   obs_arburst;
    logic [127:0] obs_wdata;
    int obs_ar_bad, obs_busy_bad, obs_rready_bad, obs_early_wen, obs_wen_cnt, obs_wen_k;
    int obs_err_out, obs_latency, obs_rst_nonzero, obs_rst_arready, obs_post_activity;

    function automatic bit outs_nonzero();
        return ({mem_arvalid, mem_rready, cache_wen, cache_writing, load_err, mem_araddr,
                 mem_arlen, mem_arsize, mem_arburst, mem_arprot, mem_arid, cache_waddr,
                 cache_wdata} !== '0);
    endfunction

    // Line model: beats 0..nb-1 packed from the LSB upward, the rest zero
    function automatic logic [127:0] model_wdata(input int nb);
        logic [127:0] v = '0;
        for (int b = 0; b < nb; b++) v = v | ({96'd0, bdata[b]} << (32 * b));
        return v;
    endfunction

    function automatic logic model_err(input int nb);
        logic e = 1'b0;
        for (int b = 0; b < nb; b++) if (bresp[b] != 2'b00) e = 1'b1;
        return e;
    endfunction

    function automatic int model_latency(input int ar_wait, input int nb);
        int t = 2 + ar_wait + nb;
        for (int b = 0; b < nb; b++) t += gaps[b];
        return t;
    endfunction

    // rlast_at: beat index carrying rlast (4 = never). rst_mode: 0 none, 1 aresetn, 2 srst
    task automatic do_load(input logic [31:0] addr, input logic [7:0] id, input logic [2:0] prot,
                           input int ar_wait, input int rlast_at, input int rst_mode);
        int nb;
        int c0;
        nb = (rlast_at < 4) ? rlast_at + 1 : 4;
        obs_ar_bad = 0; obs_busy_bad = 0; obs_rready_bad = 0; obs_early_wen = 0;
        obs_wen_cnt = 0; obs_wen_k = -1; obs_err_out = 0; obs_latency = -1;
        obs_rst_nonzero = 0; obs_rst_arready = 0; obs_post_activity = 0;
        obs_arready_after = 1'b0;
        @(negedge aclk);
        obs_arready_idle = memctrl_arready;
        c0 = cyc;
        memctrl_arvalid = 1'b1;
        memctrl_araddr = addr;
        memctrl_arid = id;
        memctrl_arprot = prot;
        @(negedge aclk);
        memctrl_arvalid = 1'b0;
        memctrl_araddr = $urandom;
        obs_arvalid = mem_arvalid;
        obs_araddr = mem_araddr; obs_arlen = mem_arlen; obs_arsize = mem_arsize;
        obs_arburst = mem_arburst; obs_arid = mem_arid; obs_arprot = mem_arprot;
        for (int w = 0; w < ar_wait; w++) begin
            mem_arready = 1'b0;
            mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            mem_rlast = 1'($urandom); mem_rresp = 2'($urandom);
            @(negedge aclk);
            if (mem_arvalid !== 1'b1 || mem_araddr !== obs_araddr || mem_arlen !== obs_arlen ||
                mem_arsize !== obs_arsize || mem_arburst !== obs_arburst ||
                mem_arid !== obs_arid || mem_arprot !== obs_arprot) obs_ar_bad++;
            if (memctrl_arready !== 1'b0) obs_busy_bad++;
        end
        mem_arready = 1'b1;
        mem_rvalid = 1'($urandom); mem_rdata = $urandom; mem_rlast = 1'($urandom);
        @(negedge aclk);
        mem_arready = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                if (mem_rready !== 1'b1) obs_rready_bad++;
                mem_rvalid = 1'b0; mem_rdata = $urandom; mem_rlast = 1'($urandom);
                @(negedge aclk);
                if (cache_wen !== 1'b0) obs_early_wen++;
                if (memctrl_arready !== 1'b0) obs_busy_bad++;
            end
            if (mem_rready !== 1'b1) obs_rready_bad++;
            mem_rvalid = 1'b1; mem_rdata = bdata[b]; mem_rresp = bresp[b];
            mem_rlast = (b == rlast_at);
            @(negedge aclk);
            mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
            if (rst_mode != 0 && b == 1) break;
            if (b < nb - 1 && cache_wen !== 1'b0) obs_early_wen++;
        end
        if (rst_mode == 1) begin
            aresetn = 1'b0;
            #1;
            obs_rst_nonzero = int'(outs_nonzero());
            obs_rst_arready = int'(memctrl_arready);
            @(negedge aclk);
            aresetn = 1'b1;
        end else if (rst_mode == 2) begin
            srst = 1'b1;
            @(negedge aclk);
            srst = 1'b0;
            obs_rst_nonzero = int'(outs_nonzero());
        end
        if (rst_mode != 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge aclk);
                if (cache_wen !== 1'b0 || mem_arvalid !== 1'b0) obs_post_activity++;
            end
            obs_arready_after = memctrl_arready;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (cache_wen === 1'b1) begin
                    if (obs_wen_cnt == 0) begin
                        obs_wen_k = k; obs_latency = cyc - c0;
                        obs_wdata = cache_wdata; obs_waddr = cache_waddr;
                        obs_err = load_err; obs_writing = cache_writing;
                    end
                    obs_wen_cnt++;
                end else if (load_err !== 1'b0 || cache_writing !== 1'b0) begin
                    obs_err_out++;
                end
                if (k == 1) obs_arready_after = memctrl_arready;
                @(negedge aclk);
            end
        end
    endtask

    task automatic set_nominal_beats();
        bdata[0] = 32'h11111111; bdata[1] = 32'h22222222;
        bdata[2] = 32'h33333333; bdata[3] = 32'h44444444;
        for (int b = 0; b < 4; b++) begin bresp[b] = 2'b00; gaps[b] = 0; end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (outs_nonzero()) begin n_bad++; $display("FAIL reset_outs: got nonzero want all 0"); end
        n_cmp++; if (memctrl_arready !== 1'b0) begin n_bad++; $display("FAIL reset_arready: got %b want 0", memctrl_arready); end
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++; if (memctrl_arready !== 1'b1) begin n_bad++; $display("FAIL release_arready: got %b want 1", memctrl_arready); end
        n_cmp++; if (outs_nonzero()) begin n_bad++; $display("FAIL idle_outs: got nonzero want all 0"); end
    endtask

    task automatic test_nominal();
        logic [127:0] lit;
        lit = 128'h44444444_33333333_22222222_11111111;
        set_nominal_beats();
        do_load(32'h00001234, 8'd3, 3'd5, 0, 3, 0);
        n_cmp++; if (obs_arready_idle !== 1'b1) begin n_bad++; $display("FAIL nom_arready: got %b want 1", obs_arready_idle); end
        n_cmp++; if (obs_arvalid !== 1'b1) begin n_bad++; $display("FAIL nom_arvalid: got %b want 1", obs_arvalid); end
        n_cmp++; if (obs_araddr !== 32'h00001230) begin n_bad++; $display("FAIL nom_araddr: got %h want 00001230", obs_araddr); end
        n_cmp++; if (obs_arlen !== 8'd3) begin n_bad++; $display("FAIL nom_arlen: got %0d want 3", obs_arlen); end
        n_cmp++; if (obs_arsize !== 3'd2) begin n_bad++; $display("FAIL nom_arsize: got %0d want 2", obs_arsize); end
        n_cmp++; if (obs_arburst !== 2'd1) begin n_bad++; $display("FAIL nom_arburst: got %0d want 1", obs_arburst); end
        n_cmp++; if (obs_arid !== 8'd3) begin n_bad++; $display("FAIL nom_arid: got %0d want 3", obs_arid); end
        n_cmp++; if (obs_arprot !== 3'd5) begin n_bad++; $display("FAIL nom_arprot: got %0d want 5", obs_arprot); end
        n_cmp++; if (obs_wen_cnt != 1) begin n_bad++; $display("FAIL nom_wen_count: got %0d want 1", obs_wen_cnt); end
        n_cmp++; if (obs_waddr !== 32'h00001230) begin n_bad++; $display("FAIL nom_waddr: got %h want 00001230", obs_waddr); end
        n_cmp++; if (obs_wdata !== lit) begin n_bad++; $display("FAIL nom_wdata: got %h want %h", obs_wdata, lit); end
        n_cmp++; if (obs_err !== 1'b0 || obs_writing !== 1'b1) begin n_bad++; $display("FAIL nom_err_writing: got %b%b want 01", obs_err, obs_writing); end
        n_cmp++; if (obs_latency != 6) begin n_bad++; $display("FAIL nom_latency: got %0d want 6", obs_latency); end
        n_cmp++; if (obs_busy_bad + obs_rready_bad + obs_early_wen + obs_err_out != 0) begin n_bad++;
            $display("FAIL nom_handshake: got busy=%0d rready=%0d early=%0d errout=%0d want 0", obs_busy_bad, obs_rready_bad, obs_early_wen, obs_err_out); end
        n_cmp++; if (obs_arready_after !== 1'b1) begin n_bad++; $display("FAIL nom_arready_after: got %b want 1", obs_arready_after); end
    endtask

    task automatic test_ar_backpressure();
        set_nominal_beats();
        do_load(32'hABCD_0078, 8'hA5, 3'd2, 5, 3, 0);
        n_cmp++; if (obs_ar_bad != 0) begin n_bad++; $display("FAIL bp_ar_stable: got %0d bad cycles want 0", obs_ar_bad); end
        n_cmp++; if (obs_busy_bad != 0) begin n_bad++; $display("FAIL bp_arready: got %0d busy cycles want 0", obs_busy_bad); end
        n_cmp++; if (obs_wdata !== model_wdata(4)) begin n_bad++; $display("FAIL bp_wdata: got %h want %h", obs_wdata, model_wdata(4)); end
        n_cmp++; if (obs_latency != model_latency(5, 4)) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", obs_latency, model_latency(5, 4)); end
    endtask

    task automatic test_r_gaps();
        set_nominal_beats();
        for (int b = 1; b < 4; b++) gaps[b] = 1;
        do_load(32'h00001234, 8'd3, 3'd0, 0, 3, 0);
        n_cmp++; if (obs_wdata !== 128'h44444444_33333333_22222222_11111111) begin n_bad++; $display("FAIL gaps_wdata: got %h", obs_wdata); end
        n_cmp++; if (obs_wen_k != 0 || obs_early_wen != 0) begin n_bad++; $display("FAIL gaps_wen_timing: got k=%0d early=%0d want 0/0", obs_wen_k, obs_early_wen); end
        n_cmp++; if (obs_rready_bad != 0) begin n_bad++; $display("FAIL gaps_rready: got %0d want 0", obs_rready_bad); end
    endtask

    task automatic test_error();
        set_nominal_beats();
        bresp[2] = 2'b10;
        do_load(32'h0000_2000, 8'd7, 3'd1, 0, 3, 0);
        n_cmp++; if (obs_wen_cnt != 1 || obs_wdata !== model_wdata(4)) begin n_bad++; $display("FAIL err_line: got cnt=%0d %h want 1 %h", obs_wen_cnt, obs_wdata, model_wdata(4)); end
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", obs_err); end
        n_cmp++; if (obs_err_out != 0) begin n_bad++; $display("FAIL err_outside_write: got %0d want 0", obs_err_out); end
    endtask

    task automatic test_early_rlast();
        set_nominal_beats();
        do_load(32'h0000_1234, 8'd1, 3'd0, 0, 1, 0);
        n_cmp++; if (obs_wdata !== 128'h00000000_00000000_22222222_11111111) begin n_bad++; $display("FAIL rlast_wdata: got %h", obs_wdata); end
        n_cmp++; if (obs_wen_k != 0 || obs_wen_cnt != 1) begin n_bad++; $display("FAIL rlast_timing: got k=%0d cnt=%0d want 0/1", obs_wen_k, obs_wen_cnt); end
    endtask

    task automatic test_reset_mid_fill(input int mode);
        set_nominal_beats();
        do_load(32'h0000_4440, 8'd9, 3'd3, 0, 3, mode);
        n_cmp++; if (obs_rst_nonzero != 0) begin n_bad++; $display("FAIL rst%0d_outs: got nonzero want all 0", mode); end
        if (mode == 1) begin
            n_cmp++; if (obs_rst_arready != 0) begin n_bad++; $display("FAIL rst1_arready_low: got %0d want 0", obs_rst_arready); end
        end
        n_cmp++; if (obs_post_activity != 0) begin n_bad++; $display("FAIL rst%0d_no_write: got %0d active cycles want 0", mode, obs_post_activity); end
        n_cmp++; if (obs_arready_after !== 1'b1) begin n_bad++; $display("FAIL rst%0d_arready_after: got %b want 1", mode, obs_arready_after); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [7:0]  id;
        logic [2:0]  prot;
        int ar_wait, rlast_at, nb;
        for (int it = 0; it < 25; it++) begin
            addr = $urandom; id = 8'($urandom); prot = 3'($urandom);
            ar_wait = $urandom_range(0, 3); rlast_at = $urandom_range(0, 4);
            nb = (rlast_at < 4) ? rlast_at + 1 : 4;
            for (int b = 0; b < 4; b++) begin
                bdata[b] = $urandom;
                bresp[b] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                gaps[b] = $urandom_range(0, 2);
            end
            do_load(addr, id, prot, ar_wait, rlast_at, 0);
            n_cmp++; if (obs_araddr !== addr - (addr % 16) || obs_arid !== id || obs_arprot !== prot) begin n_bad++;
                $display("FAIL rnd%0d_ar: got %h/%h/%h want %h/%h/%h", it, obs_araddr, obs_arid, obs_arprot, addr - (addr % 16), id, prot); end
            n_cmp++; if (obs_wen_cnt != 1 || obs_waddr !== addr - (addr % 16)) begin n_bad++;
                $display("FAIL rnd%0d_waddr: got cnt=%0d %h want 1 %h", it, obs_wen_cnt, obs_waddr, addr - (addr % 16)); end
            n_cmp++; if (obs_wdata !== model_wdata(nb)) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", it, obs_wdata, model_wdata(nb)); end
            n_cmp++; if (obs_err !== model_err(nb)) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", it, obs_err, model_err(nb)); end
            n_cmp++; if (obs_latency != model_latency(ar_wait, nb)) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, obs_latency, model_latency(ar_wait, nb)); end
            n_cmp++; if (obs_ar_bad + obs_busy_bad + obs_rready_bad + obs_early_wen + obs_err_out != 0) begin n_bad++;
                $display("FAIL rnd%0d_protocol: got ar=%0d busy=%0d rready=%0d early=%0d errout=%0d want 0", it, obs_ar_bad, obs_busy_bad, obs_rready_bad, obs_early_wen, obs_err_out); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ar_backpressure();
        test_r_gaps();
        test_error();
        test_early_rlast();
        test_reset_mid_fill(1);
        test_reset_mid_fill(2);
        test_nominal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
